// File: rtl/rf_pkg.sv
// Shared constants for the bypassed register file: default geometry and
// the register-count helper used to size arrays from the address width.
package rf_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 4;
    localparam bit ZERO_REG_DEF = 1'b1;

    function automatic int nregs(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/rf_bypass_sb_if.sv
// Decode/writeback-facing bus of the register file. The master side is the
// pipeline, which drives addresses, enables and write data.
interface rf_bypass_sb_if
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic              re0, re1;
    logic [DATA_W-1:0] p0, p1;
    logic              p0_busy, p1_busy;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst;
    logic              we;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss;
    logic              hlt;

    modport master (
        output p0_addr, p1_addr, re0, re1, dst_addr, dst, we, iss_addr, iss, hlt,
        input  p0, p1, p0_busy, p1_busy
    );
    modport slave (
        input  p0_addr, p1_addr, re0, re1, dst_addr, dst, we, iss_addr, iss, hlt,
        output p0, p1, p0_busy, p1_busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, and looked up post-update so busy matches the bypassed data.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd0_busy,
    output logic              rd1_busy
);
    localparam int NREGS = nregs(ADDR_W);

    logic [NREGS-1:0] pend, pend_nxt;

    // Set beats clear: a same-edge issue names a newer producer still in flight.
    for (genvar g = 0; g < NREGS; g++) begin : g_pend
        if (ZERO_REG && g == 0) begin : g_zero
            assign pend_nxt[g] = 1'b0;
        end else begin : g_reg
            assign pend_nxt[g] = (iss && iss_addr == ADDR_W'(g)) ||
                                 (pend[g] && !(we && dst_addr == ADDR_W'(g)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    assign rd0_busy = pend_nxt[rd0_addr];
    assign rd1_busy = pend_nxt[rd1_addr];
endmodule

// File: rtl/rf_bypass_sb.sv
// Two-read/one-write flop register file with same-edge write bypass and a
// pending-write scoreboard for RAW hazard detection at decode.
module rf_bypass_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input logic           clk,
    input logic           rst,
    rf_bypass_sb_if.slave bus
);
    localparam int NREGS = nregs(ADDR_W);

    logic [NREGS-1:0][DATA_W-1:0] mem;
    logic                         wr_ok;
    logic [DATA_W-1:0]            rd0, rd1;
    logic                         busy0, busy1;
    logic                         hlt_q;

    assign wr_ok = bus.we && !(ZERO_REG && bus.dst_addr == '0);

    for (genvar g = 0; g < NREGS; g++) begin : g_mem
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                     mem[g] <= '0;
            else if (wr_ok && bus.dst_addr == ADDR_W'(g)) mem[g] <= bus.dst;
        end
    end

    always_comb begin
        rd0 = mem[bus.p0_addr];
        if (wr_ok && bus.dst_addr == bus.p0_addr) rd0 = bus.dst;
        if (ZERO_REG && bus.p0_addr == '0)        rd0 = '0;
        rd1 = mem[bus.p1_addr];
        if (wr_ok && bus.dst_addr == bus.p1_addr) rd1 = bus.dst;
        if (ZERO_REG && bus.p1_addr == '0)        rd1 = '0;
    end

    rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.we),
        .dst_addr (bus.dst_addr),
        .iss      (bus.iss),
        .iss_addr (bus.iss_addr),
        .rd0_addr (bus.p0_addr),
        .rd1_addr (bus.p1_addr),
        .rd0_busy (busy0),
        .rd1_busy (busy1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.p0      <= '0;
            bus.p0_busy <= 1'b0;
        end else if (bus.re0) begin
            bus.p0      <= rd0;
            bus.p0_busy <= busy0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.p1      <= '0;
            bus.p1_busy <= 1'b0;
        end else if (bus.re1) begin
            bus.p1      <= rd1;
            bus.p1_busy <= busy1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hlt_q <= 1'b0;
        else     hlt_q <= bus.hlt;
    end

`ifndef SYNTHESIS
    // Register dump on the rising edge of hlt; purely for simulation visibility.
    always @(posedge clk) begin
        if (!rst && bus.hlt && !hlt_q)
            for (int i = 1; i < NREGS; i++) $display("R%0d = %h", i, mem[i]);
    end
`endif
endmodule

// File: tb/tb_rf_bypass_sb.sv
// Randomized and directed bench for rf_bypass_sb against an array-level
// model: a read returns the register state as it stands after that edge's update.
module tb_rf_bypass_sb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_bypass_sb_if #(.DATA_W(16), .ADDR_W(4)) ifa();
    rf_bypass_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb();

    rf_bypass_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    rf_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    int checks = 0;
    int passed = 0;

    logic [15:0] mem_m [16];
    bit          pend_m [16];
    logic [15:0] p0_m, p1_m;
    bit          b0_m, b1_m;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 1'b0;
        end
        p0_m = '0; p1_m = '0; b0_m = 1'b0; b1_m = 1'b0;
    endtask

    // Apply this edge's write and issue to the register state, then read it.
    task automatic model_step();
        if (ifa.we && ifa.dst_addr != 0) mem_m[ifa.dst_addr] = ifa.dst;
        if (ifa.we)  pend_m[ifa.dst_addr] = 1'b0;
        if (ifa.iss) pend_m[ifa.iss_addr] = 1'b1;
        pend_m[0] = 1'b0;
        if (ifa.re0) begin p0_m = mem_m[ifa.p0_addr]; b0_m = pend_m[ifa.p0_addr]; end
        if (ifa.re1) begin p1_m = mem_m[ifa.p1_addr]; b1_m = pend_m[ifa.p1_addr]; end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("p0", ifa.p0, p0_m);
        check("p1", ifa.p1, p1_m);
        check("p0_busy", ifa.p0_busy, b0_m);
        check("p1_busy", ifa.p1_busy, b1_m);
    endtask

    task automatic idle();
        ifa.we = 0; ifa.iss = 0; ifa.re0 = 0; ifa.re1 = 0; ifa.hlt = 0;
        ifa.dst = '0; ifa.dst_addr = '0; ifa.iss_addr = '0;
        ifa.p0_addr = '0; ifa.p1_addr = '0;
        ifb.we = 0; ifb.iss = 0; ifb.re0 = 0; ifb.re1 = 0; ifb.hlt = 0;
        ifb.dst = '0; ifb.dst_addr = '0; ifb.iss_addr = '0;
        ifb.p0_addr = '0; ifb.p1_addr = '0;
    endtask

    initial begin
        idle();
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("rst_p0", ifa.p0, 16'h0);
        check("rst_p1", ifa.p1, 16'h0);
        check("rst_busy", {ifa.p0_busy, ifa.p1_busy}, 2'b00);
        @(negedge clk) rst = 1'b0;

        // Write then read, then a held port while the register changes.
        ifa.we = 1; ifa.dst_addr = 3; ifa.dst = 16'hBEEF;
        cyc();
        idle(); ifa.re0 = 1; ifa.p0_addr = 3;
        cyc();
        check("wr_rd_p0", ifa.p0, 16'hBEEF);
        idle(); ifa.we = 1; ifa.dst_addr = 3; ifa.dst = 16'h1234;
        cyc();
        check("hold_p0", ifa.p0, 16'hBEEF);

        // Same-edge bypass on port 1.
        idle(); ifa.we = 1; ifa.dst_addr = 7; ifa.dst = 16'hA5A5; ifa.re1 = 1; ifa.p1_addr = 7;
        cyc();
        check("bypass_p1", ifa.p1, 16'hA5A5);

        // Register 0: write and issue both ignored, bypass suppressed.
        idle(); ifa.we = 1; ifa.dst_addr = 0; ifa.dst = 16'hFFFF;
        ifa.iss = 1; ifa.iss_addr = 0; ifa.re0 = 1; ifa.p0_addr = 0;
        cyc();
        check("zero_p0", ifa.p0, 16'h0);
        check("zero_busy", ifa.p0_busy, 1'b0);

        // Scoreboard: issue, observe busy, writeback clears with new data.
        idle(); ifa.iss = 1; ifa.iss_addr = 4;
        cyc();
        idle(); ifa.re0 = 1; ifa.p0_addr = 4;
        cyc();
        check("sb_busy", ifa.p0_busy, 1'b1);
        idle(); ifa.we = 1; ifa.dst_addr = 4; ifa.dst = 16'h0042; ifa.re0 = 1; ifa.p0_addr = 4;
        cyc();
        check("sb_clr_busy", ifa.p0_busy, 1'b0);
        check("sb_clr_p0", ifa.p0, 16'h0042);
        idle(); ifa.we = 1; ifa.dst_addr = 4; ifa.dst = 16'h0043;
        ifa.iss = 1; ifa.iss_addr = 4; ifa.re0 = 1; ifa.p0_addr = 4;
        cyc();
        check("sb_set_wins", ifa.p0_busy, 1'b1);
        idle(); ifa.iss = 1; ifa.iss_addr = 9; ifa.re1 = 1; ifa.p1_addr = 9;
        cyc();
        check("iss_same_edge", ifa.p1_busy, 1'b1);

        // Both ports on one address.
        idle(); ifa.re0 = 1; ifa.re1 = 1; ifa.p0_addr = 3; ifa.p1_addr = 3;
        cyc();
        check("dual_p0", ifa.p0, 16'h1234);
        check("dual_p1", ifa.p1, 16'h1234);

        // Wide instance: top register round trip on both ports.
        idle(); ifb.we = 1; ifb.dst_addr = 31; ifb.dst = 32'hDEADBEEF;
        cyc();
        idle(); ifb.re0 = 1; ifb.re1 = 1; ifb.p0_addr = 31; ifb.p1_addr = 31;
        cyc();
        check("wide_p0", ifb.p0, 32'hDEADBEEF);
        check("wide_p1", ifb.p1, 32'hDEADBEEF);

        idle(); ifa.hlt = 1;
        cyc();
        idle();

        // Randomized traffic over a narrow address range to force collisions.
        for (int n = 0; n < 600; n++) begin
            ifa.we       = ($urandom_range(0, 2) != 0);
            ifa.dst_addr = 4'($urandom_range(0, 7));
            ifa.dst      = 16'($urandom);
            ifa.iss      = ($urandom_range(0, 2) == 0);
            ifa.iss_addr = 4'($urandom_range(0, 7));
            ifa.re0      = ($urandom_range(0, 3) != 0);
            ifa.re1      = ($urandom_range(0, 3) != 0);
            ifa.p0_addr  = 4'($urandom_range(0, 7));
            ifa.p1_addr  = ($urandom_range(0, 3) == 0) ? ifa.p0_addr : 4'($urandom_range(0, 15));
            cyc();
        end

        // Mid-stream asynchronous reset after known writes and a pending issue.
        idle(); ifa.we = 1; ifa.dst_addr = 5; ifa.dst = 16'h1111; ifa.iss = 1; ifa.iss_addr = 6;
        cyc();
        idle(); ifa.re0 = 1; ifa.p0_addr = 5; ifa.re1 = 1; ifa.p1_addr = 6;
        cyc();
        check("pre_rst_p0", ifa.p0, 16'h1111);
        check("pre_rst_busy", ifa.p1_busy, 1'b1);
        idle();
        rst = 1'b1;
        #1;
        check("async_rst_p0", ifa.p0, 16'h0);
        check("async_rst_p1", ifa.p1, 16'h0);
        check("async_rst_busy", {ifa.p0_busy, ifa.p1_busy}, 2'b00);
        model_reset();
        #1 rst = 1'b0;
        ifa.re0 = 1; ifa.p0_addr = 5; ifa.re1 = 1; ifa.p1_addr = 6;
        cyc();
        check("post_rst_r5", ifa.p0, 16'h0000);
        check("post_rst_busy6", ifa.p1_busy, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/rf_bypass_sb.md
# rf_bypass_sb

Parametrised successor to the pipelined processor's 16x16 triple-ported register file. It provides a flop-based register array with configurable width and depth, two read ports and one write port, all on one clock edge, with write-to-read bypass. A per-register pending-write scoreboard lets the decode stage detect RAW hazards without external bookkeeping. It sits between decode (read and issue) and writeback (write).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_addr, p1_addr  in  ADDR_W  read port addresses
- re0, re1  in  1  read enables; when low, the port holds its last output
- p0, p1  out  DATA_W  registered read data
- p0_busy, p1_busy  out  1  registered pending flag for the captured address
- dst_addr  in  ADDR_W  write address
- dst  in  DATA_W  write data
- we  in  1  write enable; also clears the pending flag of dst_addr
- iss_addr  in  ADDR_W  destination of the newly issued instruction
- iss  in  1  marks iss_addr pending
- hlt  in  1  simulation-only dump trigger

## Operation
- Write: at a rising edge with we=1, mem[dst_addr] <= dst, unless ZERO_REG=1 and dst_addr=0 (write dropped).
- Read, per port n: at a rising edge with ren=1, pn <= bypass ? dst : mem[pn_addr]. bypass = we && dst_addr==pn_addr && the write is not dropped. With ZERO_REG=1 and address 0, pn <= 0.
- Read with ren=0: pn and pn_busy hold.
- Scoreboard pend[NREGS]. Per edge:
  - we clears pend[dst_addr].
  - iss sets pend[iss_addr].
  - iss and we to the same address: set wins, because a newer producer is outstanding.
  - With ZERO_REG=1, pend[0] stays 0.
- pn_busy <= post-update pend[pn_addr], so it agrees with the bypassed data.
  - A same-edge write to that address gives busy=0, with the new data.
  - A same-edge issue to that address gives busy=1.
- Both ports may read the same address: identical results.
- hlt: detected synchronously (hlt high, registered hlt_q low). Prints `R<n> = <hex>` for registers 1..NREGS-1 via $display. No functional effect.

## Timing
- Read latency: 1 cycle (address and enable sampled at edge k, data valid after edge k).
- Write-to-read: 0 extra cycles via bypass. Read at the write edge returns the new data.
- Issue-to-busy: a read at the issue edge already reports busy=1.
- Writeback-to-clear: a read at the write edge reports busy=0.
- Reset asserts asynchronously. Mid-operation it immediately forces all of the following to 0:
  - every mem entry
  - every pend bit
  - p0, p1, p0_busy, p1_busy, hlt_q
- Out of reset, the first edge behaves normally. No sampled inputs are lost beyond the edges during which rst was high.
- No X on any output after reset. Addresses are always in range, so there is no wrap-around case.

## Structure
- Package rf_pkg holds:
  - default DATA_W and ADDR_W constants
  - localparam NREGS derivation helper
  - the ZERO_REG default
- Sub-module rf_scoreboard owns the pend vector: set/clear priority, zero-register masking, and the post-update lookup for the two read addresses.
- Array, bypass muxes and hlt dump stay in rf_bypass_sb.

## Test plan
- Reset:
  - Stimulus: assert rst mid-stream after writes.
  - Required: p0=p1=0 and busy=0 with no clock. Read of R5 after release returns 0000.
- Write then read:
  - Stimulus: write R3=BEEF at edge 1, read p0_addr=3 at edge 2.
  - Required: p0=BEEF after edge 2. re0=0 at edge 3 with dst_addr=3 writing 1234: p0 stays BEEF.
- Bypass:
  - Stimulus: we=1, dst_addr=7, dst=A5A5 and p1_addr=7 in the same cycle.
  - Required: p1=A5A5 after that edge.
- Zero register:
  - Stimulus: write R0=FFFF, iss R0.
  - Required: p0 reads 0000 and p0_busy=0, with bypass suppressed.
- Scoreboard:
  - Stimulus: iss R4 at edge 1, read R4 at edge 2, then we R4=0042 at edge 3 with a same-edge read.
  - Required: busy=1 after edge 2. After edge 3, busy=0 and p0=0042.
  - Stimulus: simultaneous iss and we on R4.
  - Required: busy stays 1.
- Width: with DATA_W=32 and ADDR_W=5, write R31=DEADBEEF and read it back on both ports. Required: identical values.
